// File: rtl/fb_muldiv_ctrl_pkg.sv
// Shared types and op decoding for the RV32M multiply/divide sequencer.
package fb_muldiv_ctrl_pkg;

  localparam int XLEN_DEFAULT = 32;

  // Bit positions of the ops inside the 8-bit one-hot from ALU control.
  localparam int OP_BIT_MUL    = 7;
  localparam int OP_BIT_MULH   = 6;
  localparam int OP_BIT_MULHSU = 5;
  localparam int OP_BIT_MULHU  = 4;
  localparam int OP_BIT_DIV    = 3;
  localparam int OP_BIT_DIVU   = 2;
  localparam int OP_BIT_REM    = 1;
  localparam int OP_BIT_REMU   = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU,
    MD_DIV, MD_DIVU, MD_REM, MD_REMU
  } md_op_e;

  // Multi-hot inputs resolve to the highest set bit (mul has top priority).
  function automatic md_op_e decode_op(input logic [7:0] onehot);
    md_op_e op;
    op = MD_REMU;
    if (onehot[OP_BIT_MUL])         op = MD_MUL;
    else if (onehot[OP_BIT_MULH])   op = MD_MULH;
    else if (onehot[OP_BIT_MULHSU]) op = MD_MULHSU;
    else if (onehot[OP_BIT_MULHU])  op = MD_MULHU;
    else if (onehot[OP_BIT_DIV])    op = MD_DIV;
    else if (onehot[OP_BIT_DIVU])   op = MD_DIVU;
    else if (onehot[OP_BIT_REM])    op = MD_REM;
    else if (onehot[OP_BIT_REMU])   op = MD_REMU;
    return op;
  endfunction

  function automatic logic op_is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU) || (op == MD_REM) || (op == MD_REMU);
  endfunction

  // Plain mul only needs the low half, which is sign-agnostic.
  function automatic logic op_src1_signed(input md_op_e op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic op_src2_signed(input md_op_e op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/fb_muldiv_ctrl_iter.sv
// One combinational step of the shift-add multiplier or restoring divider.
// Multiply: acc = {partial_high, remaining_multiplier}; operand = multiplicand.
// Divide:   acc low half = dividend shifting out MSB-first, quotient bits shift
//           in at the bottom (the caller ORs q_bit_o into acc_o[0]);
//           operand = divisor.
module fb_muldiv_ctrl_iter #(
  parameter int XLEN = 32
) (
  input  logic              is_div_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN:0]     rem_i,
  input  logic [XLEN-1:0]   opnd_i,
  output logic [2*XLEN-1:0] acc_o,
  output logic [XLEN:0]     rem_o,
  output logic              q_bit_o
);

  logic [XLEN:0]   add_sum;
  logic [XLEN:0]   rem_shift;
  logic [XLEN+1:0] trial;

  // Compute both datapaths, then pick the one for the active mode.
  always_comb begin
    add_sum = {1'b0, acc_i[2*XLEN-1:XLEN]};
    if (acc_i[0]) begin
      add_sum = add_sum + {1'b0, opnd_i};
    end
    rem_shift = {rem_i[XLEN-1:0], acc_i[XLEN-1]};
    trial     = {1'b0, rem_shift} - {2'b00, opnd_i};

    acc_o   = acc_i;
    rem_o   = rem_i;
    q_bit_o = 1'b0;
    if (is_div_i) begin
      q_bit_o = ~trial[XLEN+1];
      rem_o   = trial[XLEN+1] ? rem_shift : trial[XLEN:0];
      acc_o   = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-2:0], 1'b0};
    end else begin
      acc_o   = {add_sum, acc_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/fb_muldiv_ctrl.sv
// RV32M multi-cycle sequencer: accepts one MUL/DIV/REM op, iterates one bit
// per cycle, holds busy until the result handshake completes.
// Handshake: a request is taken on a rising edge where req_valid & req_ready
// & |muldiv_op; a result is consumed on a rising edge where resp_valid &
// resp_ready. resp_data is held stable while resp_valid is high.
module fb_muldiv_ctrl
  import fb_muldiv_ctrl_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [7:0]      muldiv_op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            busy
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  counter_q, counter_d;
  md_op_e            op_q, op_d;
  logic              neg_q, neg_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN:0]     rem_q, rem_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic              special_q, special_d;
  logic [XLEN-1:0]   special_res_q, special_res_d;
  logic              resp_valid_q, resp_valid_d;
  logic [XLEN-1:0]   resp_data_q, resp_data_d;

  // Accept-side decode
  md_op_e          op_dec;
  logic            accept;
  logic            s1, s2;
  logic [XLEN-1:0] mag1, mag2;
  logic            div_zero, div_ovf, special_hit;
  logic [XLEN-1:0] special_val;

  // Iteration step and result correction
  logic [2*XLEN-1:0] iter_acc;
  logic [XLEN:0]     iter_rem;
  logic              iter_q;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, final_res;

  fb_muldiv_ctrl_iter #(.XLEN(XLEN)) u_iter (
    .is_div_i (op_is_div(op_q)),
    .acc_i    (acc_q),
    .rem_i    (rem_q),
    .opnd_i   (opnd_q),
    .acc_o    (iter_acc),
    .rem_o    (iter_rem),
    .q_bit_o  (iter_q)
  );

  assign req_ready  = (state_q == ST_IDLE) & ~flush;
  assign accept     = req_valid & req_ready & (|muldiv_op);
  assign busy       = (state_q != ST_IDLE) | (req_valid & (|muldiv_op) & (state_q == ST_IDLE));
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;

  // Decode the incoming op: operand signs, magnitudes and the skip-CALC cases.
  always_comb begin
    op_dec      = decode_op(muldiv_op);
    s1          = op_src1_signed(op_dec) & src1[XLEN-1];
    s2          = op_src2_signed(op_dec) & src2[XLEN-1];
    mag1        = s1 ? -src1 : src1;
    mag2        = s2 ? -src2 : src2;
    div_zero    = op_is_div(op_dec) & (src2 == '0);
    div_ovf     = ((op_dec == MD_DIV) | (op_dec == MD_REM)) &
                  (src1 == INT_MIN) & (src2 == '1);
    special_hit = div_zero | div_ovf;
    special_val = '0;
    if (div_zero) begin
      special_val = ((op_dec == MD_REM) | (op_dec == MD_REMU)) ? src1 : '1;
    end else if (div_ovf) begin
      special_val = (op_dec == MD_REM) ? '0 : INT_MIN;
    end
  end

  // Turn the unsigned magnitude result back into the architectural value.
  always_comb begin
    prod_fix  = neg_q ? -acc_q : acc_q;
    quo_fix   = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix   = neg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
    final_res = rem_fix;
    case (op_q)
      MD_MUL:                       final_res = prod_fix[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              final_res = quo_fix;
      default:                      final_res = rem_fix;
    endcase
  end

  // Next-state logic: accept, iterate, present result; flush wins over all.
  always_comb begin
    state_d       = state_q;
    counter_d     = counter_q;
    op_d          = op_q;
    neg_d         = neg_q;
    acc_d         = acc_q;
    rem_d         = rem_q;
    opnd_d        = opnd_q;
    special_d     = special_q;
    special_res_d = special_res_q;
    resp_valid_d  = resp_valid_q;
    resp_data_d   = resp_data_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d          = op_dec;
          counter_d     = '0;
          special_d     = special_hit;
          special_res_d = special_val;
          rem_d         = '0;
          if ((op_dec == MD_REM) | (op_dec == MD_REMU)) begin
            neg_d = s1;
          end else begin
            neg_d = s1 ^ s2;
          end
          if (op_is_div(op_dec)) begin
            acc_d  = {{XLEN{1'b0}}, mag1};
            opnd_d = mag2;
          end else begin
            acc_d  = {{XLEN{1'b0}}, mag2};
            opnd_d = mag1;
          end
          state_d = special_hit ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        acc_d     = iter_acc | {{(2*XLEN-1){1'b0}}, iter_q};
        rem_d     = iter_rem;
        counter_d = counter_q + CNT_W'(1);
        if (counter_q == CNT_LAST) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!resp_valid_q) begin
          resp_valid_d = 1'b1;
          resp_data_d  = special_q ? special_res_q : final_res;
        end else if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (flush) begin
      state_d      = ST_IDLE;
      resp_valid_d = 1'b0;
      counter_d    = '0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      counter_q     <= '0;
      op_q          <= MD_MUL;
      neg_q         <= 1'b0;
      acc_q         <= '0;
      rem_q         <= '0;
      opnd_q        <= '0;
      special_q     <= 1'b0;
      special_res_q <= '0;
      resp_valid_q  <= 1'b0;
      resp_data_q   <= '0;
    end else begin
      state_q       <= state_d;
      counter_q     <= counter_d;
      op_q          <= op_d;
      neg_q         <= neg_d;
      acc_q         <= acc_d;
      rem_q         <= rem_d;
      opnd_q        <= opnd_d;
      special_q     <= special_d;
      special_res_q <= special_res_d;
      resp_valid_q  <= resp_valid_d;
      resp_data_q   <= resp_data_d;
    end
  end

endmodule

// File: tb/tb_fb_muldiv_ctrl.sv
// Bench for fb_muldiv_ctrl: directed RV32M cases plus randomized ops checked
// against an arithmetic reference model.
module tb_fb_muldiv_ctrl;

  localparam int XLEN = 32;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid;
  logic            req_ready;
  logic [7:0]      muldiv_op;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic            flush;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_data;
  logic            busy;

  int n_checks = 0;
  int n_errors = 0;
  logic [XLEN-1:0] exp_q[$];

  fb_muldiv_ctrl #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .muldiv_op  (muldiv_op),
    .src1       (src1),
    .src2       (src2),
    .flush      (flush),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .busy       (busy)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Op index: 7 mul, 6 mulh, 5 mulhsu, 4 mulhu, 3 div, 2 divu, 1 rem, 0 remu.
  function automatic int top_op(input logic [7:0] oh);
    int r;
    r = -1;
    for (int i = 0; i < 8; i++) if (oh[i]) r = i;
    return r;
  endfunction

  function automatic logic is_special(input int op, input logic [31:0] a, input logic [31:0] b);
    if (op <= 3 && b == 32'h0) return 1'b1;
    if ((op == 3 || op == 1) && a == INT_MIN && b == 32'hFFFF_FFFF) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_result(input int op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    case (op)
      7: begin p = ua * ub; return p[31:0]; end
      6: begin p = sa * sb; return p[63:32]; end
      5: begin p = sa * ub; return p[63:32]; end
      4: begin p = ua * ub; return p[63:32]; end
      3: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (a == INT_MIN && b == 32'hFFFF_FFFF) return INT_MIN;
        return $signed(a) / $signed(b);
      end
      2: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        return a / b;
      end
      1: begin
        if (b == 32'h0) return a;
        if (a == INT_MIN && b == 32'hFFFF_FFFF) return 32'h0;
        return $signed(a) % $signed(b);
      end
      default: begin
        if (b == 32'h0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Issue one request, wait for its result, optionally stall the consumer.
  task automatic run_op(input string tag, input logic [7:0] oh,
                        input logic [31:0] a, input logic [31:0] b, input int hold);
    int op, lat, exp_lat;
    logic [31:0] exp;
    op = top_op(oh);
    exp_q.push_back(ref_result(op, a, b));
    exp_lat = is_special(op, a, b) ? 1 : XLEN + 1;

    @(negedge clk);
    req_valid = 1'b1; muldiv_op = oh; src1 = a; src2 = b;
    #1;
    check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    check({tag, ".busy_req"}, 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0; muldiv_op = 8'h00; src1 = $urandom; src2 = $urandom;

    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (resp_valid) break;
      check({tag, ".busy_calc"}, 32'(busy), 32'd1);
    end
    exp = exp_q.pop_front();
    check({tag, ".valid"}, 32'(resp_valid), 32'd1);
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ".data"}, resp_data, exp);
    check({tag, ".busy_done"}, 32'(busy), 32'd1);

    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, ".hold_valid"}, 32'(resp_valid), 32'd1);
      check({tag, ".hold_data"}, resp_data, exp);
      check({tag, ".hold_req_ready"}, 32'(req_ready), 32'd0);
    end

    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    check({tag, ".post_valid"}, 32'(resp_valid), 32'd0);
    check({tag, ".post_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, ".post_busy"}, 32'(busy), 32'd0);
  endtask

  // Start an op, then kill it with flush or rst after the given CALC cycles.
  task automatic abort_op(input string tag, input int cycles, input logic use_rst);
    logic seen;
    @(negedge clk);
    req_valid = 1'b1; muldiv_op = 8'h80; src1 = 32'd12345; src2 = 32'd678;
    @(posedge clk);
    #1 req_valid = 1'b0; muldiv_op = 8'h00;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    if (use_rst) rst = 1'b1; else flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, ".valid"}, 32'(resp_valid), 32'd0);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    if (use_rst) begin
      check({tag, ".data"}, resp_data, 32'd0);
    end
    rst = 1'b0; flush = 1'b0;
    #1;
    check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (resp_valid || busy) seen = 1'b1;
    end
    check({tag, ".quiet"}, 32'(seen), 32'd0);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return INT_MIN;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [7:0] oh;
    logic seen;
    rst = 1'b1; req_valid = 1'b0; muldiv_op = 8'h00; src1 = '0; src2 = '0;
    flush = 1'b0; resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.valid", 32'(resp_valid), 32'd0);
    check("reset.data", resp_data, 32'd0);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.req_ready", 32'(req_ready), 32'd1);
    rst = 1'b0;

    // Directed arithmetic cases
    run_op("mul_7x-3",       8'h80, 32'd7, -32'd3, 0);
    run_op("mulh_min",       8'h40, INT_MIN, INT_MIN, 0);
    run_op("mulhu_ones",     8'h10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("mulhsu_m1",      8'h20, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("div_-20_3",      8'h08, -32'd20, 32'd3, 0);
    run_op("rem_-20_3",      8'h02, -32'd20, 32'd3, 0);
    run_op("divu_100_7",     8'h04, 32'd100, 32'd7, 0);
    run_op("remu_100_7",     8'h01, 32'd100, 32'd7, 0);
    run_op("div_5_0",        8'h08, 32'd5, 32'd0, 0);
    run_op("rem_5_0",        8'h02, 32'd5, 32'd0, 0);
    run_op("div_ovf",        8'h08, INT_MIN, 32'hFFFF_FFFF, 0);
    run_op("rem_ovf",        8'h02, INT_MIN, 32'hFFFF_FFFF, 0);
    run_op("backpressure",   8'h80, 32'd1234, 32'd5678, 10);
    run_op("multihot_div",   8'h09, 32'd100, 32'd7, 0);
    run_op("multihot_mul",   8'hC0, 32'hFFFF_FFFF, 32'd2, 0);

    // All-zero op is never accepted
    @(negedge clk);
    req_valid = 1'b1; muldiv_op = 8'h00; src1 = 32'd3; src2 = 32'd4;
    #1 check("zero_op.busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (resp_valid || busy) seen = 1'b1;
    end
    check("zero_op.quiet", 32'(seen), 32'd0);

    // Flush alongside a request in IDLE blocks the accept
    @(negedge clk);
    req_valid = 1'b1; muldiv_op = 8'h80; src1 = 32'd3; src2 = 32'd4; flush = 1'b1;
    #1 check("idle_flush.req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1 req_valid = 1'b0; muldiv_op = 8'h00; flush = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (resp_valid || busy) seen = 1'b1;
    end
    check("idle_flush.quiet", 32'(seen), 32'd0);

    abort_op("flush_calc15", 15, 1'b0);
    abort_op("rst_calc20", 20, 1'b1);
    run_op("after_abort", 8'h40, -32'd5, 32'd9, 0);

    // Randomized ops
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 4) == 0) oh = 8'($urandom_range(1, 255));
      else oh = 8'h01 << $urandom_range(0, 7);
      run_op("rand", oh, rand_operand(), rand_operand(), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
